nios2e_cpu_debug_scan_master: RTL and testbench
===============================================

NIOS2E_CPU_DEBUG_SCAN_MASTER -- requirements
Module: nios2e_cpu_debug_scan_master

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 38, debug data-register length in bits.
REQ-002 SHALL have parameter IR_WIDTH, default 2, virtual instruction-register width.
REQ-003 SHALL have parameter TCK_DIV, default 2 (minimum 1), clk cycles per vji_tck half-period.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  scan command offered.
- cmd_ready  out  1  command accepted on the cycle where cmd_valid and cmd_ready are both high.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_data  in  DR_WIDTH  data to shift in.
- rsp_valid  out  1  captured response available.
- rsp_ready  in  1  response consumed on the cycle where rsp_valid and rsp_ready are both high.
- rsp_data  out  DR_WIDTH  bits captured from vji_tdo.
- vji_tck  out  1  generated scan clock.
- vji_tdi  out  1  serial data to the debug slave.
- vji_tdo  in  1  serial data from the debug slave.
- vji_ir_in  out  IR_WIDTH  instruction presented to the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual TAP state strobes.

Function
REQ-005 SHALL implement the FSM IDLE -> UIR -> CDR -> SHIFT -> UDR -> RTI -> RESP -> IDLE.
REQ-006 SHALL assert cmd_ready only in IDLE, and SHALL capture cmd_ir and cmd_data on acceptance; cmd_valid SHALL be ignored in every other state.
REQ-007 SHALL hold each of UIR, CDR, UDR and RTI for exactly one vji_tck period (2*TCK_DIV clks), and SHIFT for exactly DR_WIDTH periods.
REQ-008 SHALL drive vji_tck low for the first TCK_DIV clks of each period and high for the second TCK_DIV clks; vji_tck SHALL be low in IDLE and RESP.
REQ-009 SHALL assert each strobe for the entire period of its matching state and deassert it otherwise; vji_rti SHALL also be high in IDLE.
REQ-010 SHALL drive vji_ir_in = captured cmd_ir from UIR through UDR, and hold its last value otherwise.
REQ-011 SHALL shift LSB first in SHIFT: vji_tdi updates at each period start; vji_tdo is sampled on the clk edge where vji_tck rises.
REQ-012 SHALL place the first sampled vji_tdo bit in rsp_data[0] and the last in rsp_data[DR_WIDTH-1]; vji_tdi SHALL be 0 outside SHIFT.
REQ-013 SHALL assert rsp_valid exactly (DR_WIDTH+4)*2*TCK_DIV+1 clks after the accepting edge (e.g. 169 at defaults).
REQ-014 SHALL hold rsp_valid and rsp_data stable in RESP until rsp_ready; the response SHALL be consumed on the cycle rsp_valid and rsp_ready are both high, and the FSM SHALL return to IDLE the next cycle.
REQ-015 SHALL NOT accept a new command on the same cycle a response is consumed.

Reset
REQ-016 On reset: FSM -> IDLE; cmd_ready=1, rsp_valid=0, rsp_data=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1, all other strobes 0; divider and bit counter cleared.
REQ-017 Reset mid-scan SHALL abort the scan and discard its response, producing the REQ-016 values on the next clk.

Configuration
REQ-018 With DEBUG_SCAN_IR_CACHE_EN defined: the last loaded IR is cached (cache invalidated by reset); a command whose cmd_ir equals a valid cached IR SHALL skip UIR, and the latency SHALL be reduced by 2*TCK_DIV clks.
REQ-019 Without DEBUG_SCAN_IR_CACHE_EN: every command SHALL pass through UIR.

Structure
REQ-020 Package nios2e_cpu_debug_scan_pkg SHALL hold the FSM state enum and default DR_WIDTH/IR_WIDTH constants.
REQ-021 SHALL instantiate one sub-module, nios2e_cpu_debug_scan_tckgen (divider producing vji_tck, period-start pulse and rising-edge pulse); all other logic SHALL live in the top module.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Slave model loads 38'h2A_5A5A_5A5A at CDR; cmd ir=2'b01, data=38'h3F_FFFF_FFFF -> rsp_data=38'h2A_5A5A_5A5A; model receives 38'h3F_FFFF_FFFF; rsp_valid at clk 169.
- TCK_DIV=1, data=38'h00_0000_0001 -> vji_tdi=1 only in the first SHIFT period; 38 tck rising edges seen with vji_sdr high.
- rsp_ready held low 20 clks -> rsp_valid and rsp_data stable throughout; cmd_ready=0 throughout; cmd_ready=1 the clk after consumption.
- reset pulsed during SHIFT bit 17 -> next clk all REQ-016 values; no rsp_valid is produced.
- With DEBUG_SCAN_IR_CACHE_EN, two back-to-back ir=2'b10 commands -> second command shows no vji_uir pulse and rsp_valid at clk 165; a third command with ir=2'b11 shows a UIR pulse.
- cmd_valid asserted while busy -> ignored; no second scan begins until the first response is consumed.

Source files
------------

// File: rtl/nios2e_cpu_debug_scan_pkg.sv
// Shared types and default geometry for the Nios II/e debug scan master.
package nios2e_cpu_debug_scan_pkg;

  localparam int unsigned DEF_DR_WIDTH = 38;
  localparam int unsigned DEF_IR_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } scan_state_e;

endpackage

// File: rtl/nios2e_cpu_debug_scan_tckgen.sv
// Scan-clock divider: one vji_tck period is 2*TCK_DIV clks, low half first.
module nios2e_cpu_debug_scan_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tck_o,
  output logic prd_start_o,
  output logic rise_o
);

  localparam int unsigned PERIOD = 2 * TCK_DIV;
  localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q;

  // prd_start_o marks the clk edge that opens the next period
  assign prd_start_o = en_i && (cnt_q == CW'(PERIOD - 1));
  assign rise_o      = en_i && (cnt_q == CW'(TCK_DIV - 1));
  assign tck_o       = tck_q;

  always_comb begin
    cnt_d = prd_start_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= (cnt_d >= CW'(TCK_DIV));
    end
  end

endmodule

// File: rtl/nios2e_cpu_debug_scan_master.sv
// Runs one virtual-JTAG IR+DR scan per command and returns the captured DR.
// Build option DEBUG_SCAN_IR_CACHE_EN: skip UIR when the requested IR is already loaded.
module nios2e_cpu_debug_scan_master
  import nios2e_cpu_debug_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned BW = $clog2(DR_WIDTH + 1);

  scan_state_e state_q, state_d;
  logic                scan_en, prd_start, tck_rise, last_bit, accept, ir_hit;
  logic [BW-1:0]       bit_q;
  logic [DR_WIDTH-1:0] sr_q, rx_q, rsp_data_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic cmd_ready_q, rsp_valid_q, tdi_q;
  logic uir_q, cdr_q, sdr_q, udr_q, rti_q;

  assign scan_en  = state_q inside {ST_UIR, ST_CDR, ST_SHIFT, ST_UDR, ST_RTI};
  assign last_bit = (bit_q == BW'(DR_WIDTH - 1));
  assign accept   = (state_q == ST_IDLE) && cmd_valid;

  nios2e_cpu_debug_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (scan_en),
    .tck_o      (vji_tck),
    .prd_start_o(prd_start),
    .rise_o     (tck_rise)
  );

`ifdef DEBUG_SCAN_IR_CACHE_EN
  logic ir_valid_q;
  always_ff @(posedge clk) begin
    if (reset)       ir_valid_q <= 1'b0;
    else if (accept) ir_valid_q <= 1'b1;
  end
  assign ir_hit = ir_valid_q && (cmd_ir == ir_q);
`else
  assign ir_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ir_hit ? ST_CDR : ST_UIR;
      ST_UIR:   if (prd_start) state_d = ST_CDR;
      ST_CDR:   if (prd_start) state_d = ST_SHIFT;
      ST_SHIFT: if (prd_start && last_bit) state_d = ST_UDR;
      ST_UDR:   if (prd_start) state_d = ST_RTI;
      ST_RTI:   if (prd_start) state_d = ST_RESP;
      ST_RESP:  if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tdi_q       <= 1'b0;
      ir_q        <= '0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
      bit_q       <= '0;
      sr_q        <= '0;
      rx_q        <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      uir_q       <= (state_d == ST_UIR);
      cdr_q       <= (state_d == ST_CDR);
      sdr_q       <= (state_d == ST_SHIFT);
      udr_q       <= (state_d == ST_UDR);
      rti_q       <= (state_d == ST_RTI) || (state_d == ST_IDLE);

      if (accept) begin
        ir_q  <= cmd_ir;
        sr_q  <= cmd_data;
        bit_q <= '0;
      end

      // tdi changes only on period boundaries; any period that is not SHIFT drives 0
      if (prd_start) begin
        if (state_d == ST_SHIFT) begin
          tdi_q <= sr_q[0];
          sr_q  <= sr_q >> 1;
        end else begin
          tdi_q <= 1'b0;
        end
        if (state_q == ST_SHIFT && !last_bit) bit_q <= bit_q + 1'b1;
      end

      if (state_q == ST_SHIFT && tck_rise) rx_q <= {vji_tdo, rx_q[DR_WIDTH-1:1]};

      if (state_q == ST_RESP && !rsp_valid_q) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= rx_q;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: tb/tb_nios2e_cpu_debug_scan_master.sv
// Bench for nios2e_cpu_debug_scan_master: timeline model plus virtual-JTAG slave model.
module tb_nios2e_cpu_debug_scan_master;

  localparam int unsigned DR = 38;
  localparam int unsigned IR = 2;
  localparam int TD = 2;
  localparam int P  = 2 * TD;
`ifdef DEBUG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [IR-1:0] cmd_ir, vji_ir_in;
  logic [DR-1:0] cmd_data, rsp_data;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic c1_valid, c1_ready, r1_valid;
  logic r1_ready = 1'b1;
  logic [IR-1:0] c1_ir, ir1;
  logic [DR-1:0] c1_data, r1_data;
  logic tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  nios2e_cpu_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  // second instance at TCK_DIV=1 with tdo looped back to tdi
  nios2e_cpu_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_ir(c1_ir), .cmd_data(c1_data), .rsp_valid(r1_valid), .rsp_ready(r1_ready),
    .rsp_data(r1_data), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdi1),
    .vji_ir_in(ir1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
    .vji_udr(udr1), .vji_rti(rti1)
  );

  // virtual-JTAG slave: loads slave_v at capture, shifts LSB first on tck rise
  logic [DR-1:0] slave_v = '0;
  logic [DR-1:0] slave_sr = '0;
  logic [DR-1:0] slave_rx = '0;
  int sdr_rises = 0;
  assign vji_tdo = slave_sr[0];
  always @(posedge vji_tck) begin
    if (vji_cdr) begin
      slave_sr <= slave_v;
      slave_rx <= '0;
    end else if (vji_sdr) begin
      slave_rx  <= {vji_tdi, slave_rx[DR-1:1]};
      slave_sr  <= slave_sr >> 1;
      sdr_rises <= sdr_rises + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // timeline model: m_k is the cycle index since the accepting edge
  bit m_busy = 1'b0;
  bit m_skip = 1'b0;
  bit m_cache_ok = 1'b0;
  int m_k = 0;
  logic [IR-1:0] m_ir = '0;
  logic [DR-1:0] m_data = '0;
  logic [DR-1:0] m_v = '0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_k = 0; m_ir = '0; m_cache_ok = 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_skip = CACHE && m_cache_ok && (cmd_ir == m_ir);
        m_ir = cmd_ir; m_cache_ok = 1'b1;
        m_data = cmd_data; m_v = slave_v;
        m_busy = 1'b1; m_k = 0;
      end
    end else begin
      if (m_k >= (DR + 4 - int'(m_skip)) * P + 1 && rsp_ready) m_busy = 1'b0;
      else m_k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic e_rdy, e_rv, e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti;
      int np, q;
      e_rdy = !m_busy; e_rv = 1'b0; e_tck = 1'b0; e_tdi = 1'b0;
      e_uir = 1'b0; e_cdr = 1'b0; e_sdr = 1'b0; e_udr = 1'b0; e_rti = !m_busy;
      if (m_busy) begin
        np = DR + 4 - int'(m_skip);
        if (m_k < np * P) begin
          q = m_k / P + int'(m_skip);
          e_tck = (m_k % P) >= TD;
          e_uir = (q == 0);
          e_cdr = (q == 1);
          e_sdr = (q >= 2) && (q <= DR + 1);
          if (e_sdr) e_tdi = m_data[q-2];
          e_udr = (q == DR + 2);
          e_rti = (q == DR + 3);
        end else begin
          e_rv = (m_k >= np * P + 1);
        end
      end
      check("cmd_ready", cmd_ready, e_rdy);
      check("rsp_valid", rsp_valid, e_rv);
      check("vji_tck", vji_tck, e_tck);
      check("vji_tdi", vji_tdi, e_tdi);
      check("vji_uir", vji_uir, e_uir);
      check("vji_cdr", vji_cdr, e_cdr);
      check("vji_sdr", vji_sdr, e_sdr);
      check("vji_udr", vji_udr, e_udr);
      check("vji_rti", vji_rti, e_rti);
      check("vji_ir_in", vji_ir_in, m_ir);
      if (e_rv) check("rsp_data", rsp_data, m_v);
    end
  end

  task automatic send(input logic [IR-1:0] ir, input logic [DR-1:0] data, input logic [DR-1:0] v);
    slave_v = v; cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int uirc);
    lat = 0;
    uirc = vji_uir ? 1 : 0;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
      if (vji_uir) uirc++;
    end
  endtask

  task automatic consume(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_tck"}, vji_tck, 0);
    check({tag, "_tdi"}, vji_tdi, 0);
    check({tag, "_ir_in"}, vji_ir_in, 0);
    check({tag, "_rti"}, vji_rti, 1);
    check({tag, "_strobes"}, {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
  endtask

  initial begin
    int lat, uirc, n, base, tdic, first, rises, cnt;
    logic sdr_first, prev;
    logic [63:0] rnd, rnd2;
    logic [DR-1:0] d, exp_r;

    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
    c1_valid = 1'b0; c1_ir = '0; c1_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    // directed scan with a slow consumer and a competing command
    send(2'b01, 38'h3F_FFFF_FFFF, 38'h2A_5A5A_5A5A);
    wait_rsp(lat, uirc);
    check("s1_latency", lat, 169);
    check("s1_uir_cycles", uirc, P);
    check("s1_rsp_data", rsp_data, 38'h2A_5A5A_5A5A);
    check("s1_slave_rx", slave_rx, 38'h3F_FFFF_FFFF);
    exp_r = 38'h2A_5A5A_5A5A;
    cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_data = 38'h15_1234_5678;
    for (int i = 0; i < 20; i++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_r);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_no_scan", {vji_uir, vji_cdr, vji_sdr}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ready_after_consume", cmd_ready, 1);
    check("valid_after_consume", rsp_valid, 0);

    // IR cache behaviour
    send(2'b10, 38'h01_0203_0405, 38'h3A_0B0C_0D0E);
    wait_rsp(lat, uirc);
    check("c1_latency", lat, 169);
    check("c1_uir_cycles", uirc, P);
    consume(0);
    send(2'b10, 38'h2B_CDEF_0123, 38'h11_2233_4455);
    wait_rsp(lat, uirc);
    check("c2_latency", lat, CACHE ? 165 : 169);
    check("c2_uir_cycles", uirc, CACHE ? 0 : P);
    check("c2_rsp_data", rsp_data, 38'h11_2233_4455);
    check("c2_slave_rx", slave_rx, 38'h2B_CDEF_0123);
    consume(0);
    send(2'b11, 38'h00_0000_00FF, 38'h00_0000_0000);
    wait_rsp(lat, uirc);
    check("c3_latency", lat, 169);
    check("c3_uir_cycles", uirc, P);
    consume(1);

    // TCK_DIV=1 instance, single set bit
    c1_ir = 2'b01; c1_data = 38'h00_0000_0001; c1_valid = 1'b1;
    @(negedge clk);
    c1_valid = 1'b0;
    n = 0; tdic = 0; first = -1; rises = 0; prev = 1'b0; sdr_first = 1'b0;
    while (!r1_valid && n < 200) begin
      if (tdi1) begin
        tdic++;
        if (first < 0) begin first = n; sdr_first = sdr1; end
      end
      if (tck1 && !prev && sdr1) rises++;
      prev = tck1;
      @(negedge clk);
      n++;
    end
    check("d1_latency", n, 85);
    check("d1_tdi_cycles", tdic, 2);
    check("d1_tdi_first", first, 4);
    check("d1_tdi_in_sdr", sdr_first, 1);
    check("d1_sdr_rises", rises, 38);
    check("d1_rsp_data", r1_data, 38'h00_0000_0001);
    @(negedge clk);
    check("d1_ready", c1_ready, 1);
    check("d1_idle_rti", rti1, 1);
    check("d1_ir", ir1, 2'b01);
    check("d1_idle_strobes", {uir1, cdr1, sdr1, udr1, tck1}, 0);

    // randomized commands, random busy-time cmd_valid noise, random consumer delay
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rnd = {$urandom, $urandom};
      rnd2 = {$urandom, $urandom};
      d = rnd[DR-1:0];
      send(IR'($urandom_range(0, 3)), d, rnd2[DR-1:0]);
      n = 0;
      while (!rsp_valid && n < 400) begin
        rnd = {$urandom, $urandom};
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_ir = IR'($urandom_range(0, 3));
        cmd_data = rnd[DR-1:0];
        @(negedge clk);
        n++;
      end
      check("rand_rsp_seen", rsp_valid, 1);
      check("rand_slave_rx", slave_rx, d);
      consume($urandom_range(0, 5));
    end

    // reset during SHIFT bit 17
    rnd = {$urandom, $urandom};
    send(2'b00, rnd[DR-1:0], 38'h25_5555_AAAA);
    base = sdr_rises;
    n = 0;
    while (!(vji_sdr && (sdr_rises - base) == 17 && !vji_tck) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_at_bit17", sdr_rises - base, 17);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("abort");
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_rsp", cnt, 0);

    send(2'b00, 38'h0F_0F0F_0F0F, 38'h30_C30C_30C3);
    wait_rsp(lat, uirc);
    check("post_abort_latency", lat, 169);
    check("post_abort_rsp", rsp_data, 38'h30_C30C_30C3);
    consume(0);
    repeat (2) @(negedge clk);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
